// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg: shared types and constants for the instruction-memory loader.
//   state_e   : loader FSM states
//   HDR_BYTES : length header size in bytes
//   CSUM_W    : width of the running checksum (INSTR_LOADER_CHECKSUM_EN builds)
package instr_loader_pkg;

    typedef enum logic [2:0] {
        HDR  = 3'd0,
        DATA = 3'd1,
        CSUM = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_e;

    localparam int HDR_BYTES = 4;
    localparam int CSUM_W    = 8;

endpackage

// File: rtl/instr_loader_pack.sv
// instr_loader_pack: byte-lane assembler for 32-bit little-endian words.
//   clk, rstn  : clock, asynchronous active-low reset
//   in_valid   : byte strobe
//   in_byte    : byte value
//   in_lane    : destination lane (0 = bits 7:0)
//   in_last    : byte is the final one of the image; emit even if lanes remain
//   word_rdy   : combinational strobe, word complete this cycle
//   word       : packed word including the current byte; unfilled lanes are 0
module instr_loader_pack (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    input  logic [1:0]  in_lane,
    input  logic        in_last,
    output logic        word_rdy,
    output logic [31:0] word
);

    logic [3:0][7:0] lanes_q, lanes_d, merged;

    always_comb begin
        merged          = lanes_q;
        merged[in_lane] = in_byte;
        word_rdy        = in_valid && ((in_lane == 2'd3) || in_last);
        word            = merged;
        lanes_d         = lanes_q;
        // Clearing on emit is what keeps the upper lanes of a short final word at 0.
        if (in_valid) lanes_d = word_rdy ? '0 : merged;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) lanes_q <= '0;
        else       lanes_q <= lanes_d;
    end

endmodule

// File: rtl/instr_loader.sv
// instr_loader: parses a 4-byte little-endian length header from a UART byte
// stream, then packs the image into 32-bit words written to instruction memory.
//   clk, rstn     : clock, asynchronous active-low reset
//   rx_valid/data : incoming byte strobe and value (no backpressure)
//   wr_en/addr/data : registered one-cycle word write; addr/data hold otherwise
//   busy          : header or image reception in progress
//   done          : image complete (sticky)
//   len_err       : header length larger than memory (sticky, terminal)
//   checksum_err  : trailing checksum byte mismatched (sticky)
// Optional feature: define INSTR_LOADER_CHECKSUM_EN to expect one trailing
// byte holding the mod-256 sum of the data bytes; otherwise checksum_err = 0.
module instr_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              len_err,
    output logic              checksum_err
);

    import instr_loader_pkg::*;

    localparam logic [31:0] MEM_BYTES = 32'(1) << ADDR_W;

    state_e            state_q, state_d;
    logic [1:0]        hdr_cnt_q, hdr_cnt_d;
    logic [23:0]       hdr_q, hdr_d;
    logic [ADDR_W-1:0] last_q, last_d;   // index of the final data byte (len-1)
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic [31:0]       len32;
    logic              pk_valid, pk_last, pk_rdy;
    logic [31:0]       pk_word;
    logic              csum_ok;

    // Full length becomes visible only as the 4th header byte arrives.
    assign len32 = {rx_data, hdr_q};

`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam state_e AFTER_DATA = CSUM;
    logic [CSUM_W-1:0] sum_q, sum_d;
    logic              cerr_q, cerr_d;
    assign csum_ok = (rx_data == sum_q);
`else
    localparam state_e AFTER_DATA = DONE;
    assign csum_ok = 1'b1;
`endif

    instr_loader_pack u_pack (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (pk_valid),
        .in_byte  (rx_data),
        .in_lane  (cnt_q[1:0]),
        .in_last  (pk_last),
        .word_rdy (pk_rdy),
        .word     (pk_word)
    );

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= HDR;
        else       state_q <= state_d;
    end

    // Next state plus header/counter bookkeeping
    always_comb begin
        state_d   = state_q;
        hdr_cnt_d = hdr_cnt_q;
        hdr_d     = hdr_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        case (state_q)
            HDR: if (rx_valid) begin
                hdr_cnt_d = hdr_cnt_q + 2'd1;
                cnt_d     = '0;
                case (hdr_cnt_q)
                    2'd0: hdr_d[7:0]   = rx_data;
                    2'd1: hdr_d[15:8]  = rx_data;
                    2'd2: hdr_d[23:16] = rx_data;
                    default: begin
                        // Low bits minus one also covers len == MEM_BYTES (all ones).
                        last_d = len32[ADDR_W-1:0] - ADDR_W'(1);
                        if (len32 > MEM_BYTES)  state_d = ERR;
                        else if (len32 == 32'd0) state_d = AFTER_DATA;
                        else                     state_d = DATA;
                    end
                endcase
            end
            DATA: if (rx_valid) begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == last_q) state_d = AFTER_DATA;
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            CSUM: if (rx_valid) state_d = DONE;
`endif
            default: state_d = state_q;
        endcase
    end

    // Outputs
    always_comb begin
        pk_valid = rx_valid && (state_q == DATA);
        pk_last  = (cnt_q == last_q);
        busy     = ((state_q == HDR) && (hdr_cnt_q != 2'd0)) ||
                   (state_q == DATA) || (state_q == CSUM);
        done     = (state_q == DONE);
        len_err  = (state_q == ERR);
    end

    // Write port: registered strobe, address/data hold between writes
    always_comb begin
        wr_en_d   = pk_rdy;
        wr_addr_d = pk_rdy ? {cnt_q[ADDR_W-1:2], 2'b00} : wr_addr_q;
        wr_data_d = pk_rdy ? pk_word : wr_data_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hdr_cnt_q <= '0;
            hdr_q     <= '0;
            last_q    <= '0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            hdr_cnt_q <= hdr_cnt_d;
            hdr_q     <= hdr_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

`ifdef INSTR_LOADER_CHECKSUM_EN
    always_comb begin
        sum_d  = sum_q;
        cerr_d = cerr_q;
        if (pk_valid) sum_d = sum_q + rx_data;
        if (rx_valid && (state_q == CSUM) && !csum_ok) cerr_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sum_q  <= '0;
            cerr_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cerr_q <= cerr_d;
        end
    end

    assign checksum_err = cerr_q;
`else
    assign checksum_err = 1'b0;
    logic unused_csum;
    assign unused_csum = csum_ok;
`endif

endmodule
